// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: PicoRV32-native MMIO responder feeding a FIFO-backed 8N1 UART transmitter.
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          ready_q, tx_q;
  logic [31:0]   rdata_q, rdata_d;
  logic [15:0]   div_q, div_d, div_eff, bit_div_q, cnt_q;
  logic [2:0]    bit_q, cnt3;
  logic [7:0]    sh_q;
  logic          empty, full, wr, push_req, take, push, pop, last, frame;
  logic          unused_ok;
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(FIFO_DEPTH);
  assign wr        = |mem_wstrb;
  assign push_req  = mem_addr[3:2] == 2'd0 && mem_wstrb[0];
  assign take      = mem_valid && !ready_q && !(push_req && full);
  assign push      = take && push_req;
  assign frame     = state_q != IDLE;
  assign last      = cnt_q == bit_div_q - 16'd1;
  assign pop       = !empty && (state_q == IDLE || (state_q == STOP && last));
  assign div_eff   = div_q < 16'd2 ? 16'd2 : div_q;
  assign cnt3      = 3'(count_q);
  assign div_d     = {mem_wstrb[1] ? mem_wdata[15:8] : div_q[15:8],
                      mem_wstrb[0] ? mem_wdata[7:0]  : div_q[7:0]};
  assign rdata_d   = mem_addr[3:2] == 2'd1 ? {25'd0, cnt3, 1'b0, empty, full, frame} :
                     mem_addr[3:2] == 2'd2 ? {16'd0, div_q} : '0;
  assign unused_ok = ^{mem_instr, mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16]};
  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign tx        = tx_q;
  assign busy      = frame || !empty;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      div_q   <= DEFAULT_DIV;
    end else begin
      ready_q <= take;
      rdata_q <= take && !wr ? rdata_d : '0;
      if (take && wr && mem_addr[3:2] == 2'd2) div_q <= div_d;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) fifo_q[wr_ptr_q] <= mem_wdata[7:0];
  // tx trails the state by one cycle, so each bit still lasts exactly bit_div_q cycles
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      bit_div_q <= 16'd2;
      sh_q      <= '0;
    end else begin
      tx_q <= state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : 1'b1;
      case (state_q)
        IDLE:
          if (pop) begin
            state_q   <= START;
            cnt_q     <= '0;
            bit_div_q <= div_eff;
            sh_q      <= fifo_q[rd_ptr_q];
          end
        START:
          if (last) begin
            state_q <= DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
          end else cnt_q <= cnt_q + 16'd1;
        DATA:
          if (last) begin
            cnt_q <= '0;
            sh_q  <= sh_q >> 1;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else cnt_q <= cnt_q + 16'd1;
        STOP:
          if (last) begin
            cnt_q   <= '0;
            state_q <= pop ? START : IDLE;
            if (pop) begin
              bit_div_q <= div_eff;
              sh_q      <= fifo_q[rd_ptr_q];
            end
          end else cnt_q <= cnt_q + 16'd1;
      endcase
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits as a responder on the CPU's PicoRV32-style native memory interface. The CPU (initiator) writes bytes into a small FIFO through a register window; an internal state machine serialises them 8N1, LSB first, on `tx`. Address decode of the peripheral's base is done by the top-level interconnect, which gates `mem_valid`; this block decodes only `mem_addr[3:2]`.

## Interface
- `FIFO_DEPTH`, 4: transmit FIFO entries, power of two, at least 2.
- `DEFAULT_DIV`, 16'd868: reset value of DIVISOR, in clock cycles per bit.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_valid` in 1: request valid, already gated by the base-address decode.
- `mem_instr` in 1: ignored.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_addr` in 32: only bits [3:2] are used.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: nonzero means write, 0000 means read.
- `mem_rdata` out 32: read data, valid while `mem_ready` is high.
- `tx` out 1: serial line, idles high.
- `busy` out 1: high while a frame is on the line or the FIFO is non-empty.

## Operation
Register map (by `mem_addr[3:2]`):
- 0 TXDATA
  - Write with `wstrb[0]` set pushes `wdata[7:0]`.
  - Write with `wstrb[0]` clear completes with no push.
  - Read returns 0.
- 1 STATUS (read-only; writes complete and are ignored)
  - bit0: frame in progress.
  - bit1: FIFO full.
  - bit2: FIFO empty.
  - bits[6:4]: FIFO count.
  - Other bits read 0.
- 2 DIVISOR
  - Holds a 16-bit value in [15:0]. Writes honour `wstrb[1:0]` per byte.
  - A value of 0 or 1 is treated as 2.
  - Reads return the stored value unmodified.
- 3: reads 0; writes are ignored.

Bus handshake:
- A request is taken when `mem_valid` is sampled high, `mem_ready` is low, and, for a TXDATA push, FIFO count < FIFO_DEPTH.
- A TXDATA push to a full FIFO stalls: `mem_ready` is held low until a slot frees, then the push is accepted.
- The initiator holds the address, data and strobe stable until it sees `mem_ready`.
- `mem_ready` is never high on two consecutive cycles.
- `mem_rdata` is 0 whenever `mem_ready` is low.

Transmitter state machine (IDLE, START, DATA, STOP):
- IDLE: `tx`=1. If the FIFO is non-empty, pop the head, latch the effective divisor D, and go to START.
- START: `tx`=0 for D cycles.
- DATA: 8 bits, LSB first, each held for D cycles. A bit index counts 0 to 7.
- STOP: `tx`=1 for D cycles. At the end of STOP:
  - if the FIFO is non-empty, pop the head, relatch D, and go directly to START (no idle gap);
  - otherwise go to IDLE.
- D is latched per frame. A DIVISOR write mid-frame affects only the next frame.
- `busy` = (state != IDLE) || FIFO non-empty.

Boundary conditions:
- Push and pop in the same cycle leave the count unchanged, and the pushed data is preserved.
- FIFO read and write pointers wrap modulo FIFO_DEPTH.
- A pop on an empty FIFO never occurs.
- Reset mid-frame takes effect immediately (asynchronous):
  - `tx`=1, state IDLE, FIFO emptied, DIVISOR=DEFAULT_DIV;
  - `mem_ready`=0, `mem_rdata`=0, `busy`=0;
  - any pending stalled write is dropped.

## Timing
- Reset values: `mem_ready` 0, `mem_rdata` 0, `tx` 1, `busy` 0.
- Access latency: request accepted at rising edge N; `mem_ready` and `mem_rdata` are registered high for the cycle after N; both return low at edge N+1.
- Register and FIFO updates from a write are visible to a read accepted at edge N+2 or later.
- Frame latency: a push accepted at edge N to an empty FIFO with the transmitter IDLE causes:
  - the pop at edge N+1;
  - `tx` falling after edge N+2.
- Frame length is 10·D cycles. Back-to-back frames have no extra high time beyond the stop bit.

## Test plan
- Reset, then read STATUS: `mem_rdata` = 0x0000_0004, `mem_ready` is high exactly one cycle, and `tx`=1.
- Write DIVISOR=4, then read it back, expecting 0x0000_0004. Then write TXDATA=0x55: `tx` shows low×4, then 1,0,1,0,1,0,1,0 each ×4, then high×4 (40 cycles); `busy` falls after the stop bit.
- Write DIVISOR=0, then send 0xA5: every bit lasts 2 cycles; a DIVISOR read returns 0.
- With DIVISOR=4, push 6 bytes 0x01 to 0x06 back to back:
  - with FIFO_DEPTH=4, the sixth write stalls with `mem_ready` low until the first stop bit ends;
  - all six frames are sent in order with no inter-frame gap;
  - STATUS shows full (bit1) during the stall.
- While byte 0x0F is mid-frame at D=8, write DIVISOR=2: the current frame finishes at 8 cycles per bit, and the next queued byte goes out at 2 cycles per bit.
- Assert `reset` during DATA of a frame, with two bytes queued:
  - `tx` goes high immediately;
  - after release, STATUS = 0x0000_0004 and DIVISOR = 868;
  - no further frames are sent.
